scramble_conv_enc: RTL
======================

// Module: scramble_conv_enc
// PURPOSE
//  Front end of the 802.11 OFDM TX chain: takes uncoded payload bits 3 per beat.
//  Scrambles them with x^7+x^4+1 and rate-1/2 convolutionally encodes them (K=7, g0=133o, g1=171o).
//  Emits 6 coded bits per beat into the QPSK mapper's 6-bit DAT_I.
//  Closes every frame with 6 unscrambled zero tail bits (2 output beats).
// PARAMETERS
//  SEED        7'h7F  scrambler state loaded at each frame start (s[6:0]); must be nonzero
//  TAIL_BEATS  2      output beats of zero tail appended per frame (3 tail bits each)
// PORTS
//  CLK_I   in   1  single clock
//  RST_I   in   1  reset, asynchronous, active-high
//  DAT_I   in   3  payload bits; DAT_I[0] is earliest in time
//  CYC_I   in   1  frame envelope; high for the whole payload of one frame
//  STB_I   in   1  input beat valid
//  WE_I    in   1  write qualifier; a beat is offered only when CYC_I&STB_I&WE_I
//  ACK_O   out  1  input beat accepted this cycle
//  DAT_O   out  6  coded bits; DAT_O[2k]=A_k, DAT_O[2k+1]=B_k, k=0 earliest
//  CYC_O   out  1  output frame envelope
//  STB_O   out  1  output beat valid
//  WE_O    out  1  equals STB_O
//  ACK_I   in   1  downstream accepted DAT_O
// BEHAVIOUR
//  Reset (async, any time, incl. mid-frame)
//   - DAT_O=0, CYC_O=0, STB_O=0, ACK_O=0.
//   - FSM returns to IDLE; scrambler and encoder state are cleared.
//  Handshake
//   - One-entry output register.
//   - ACK_O = CYC_I&STB_I&WE_I&(state==DATA)&(~STB_O|ACK_I), combinational.
//   - On ACK_O: the output register loads the coded word next edge and STB_O=1.
//   - Latency 1 cycle. Full throughput with ACK_I held high.
//   - STB_O and DAT_O are held stable until ACK_I. ACK_I while STB_O=0 is ignored.
//  FSM: IDLE -> DATA -> TAIL -> IDLE
//   - IDLE: when CYC_I=1 is seen, load scr<=SEED and enc<=0, set CYC_O=1, go to DATA.
//     No ACK_O is given in the IDLE cycle.
//   - DATA: accept beats per the handshake. When CYC_I=0, go to TAIL (zero-length payload is legal).
//   - TAIL: emit TAIL_BEATS words coded from zero input bits. No scrambling; the scrambler is frozen.
//     Each tail word loads only when ~STB_O|ACK_I; a counter tracks the words.
//     When the last tail word is ACKed: CYC_O=0, go to IDLE.
//   - CYC_I rising during TAIL: ignored (ACK_O=0) until IDLE. Then a new frame starts.
//   - CYC_I dropping while STB_I is high: the beat is not accepted. A beat counts only with ACK_O.
//  Scrambler (per input bit, earliest first, 3 unrolled per beat)
//   - x=s[6]^s[3]; out=d^x; s<={s[5:0],x}.
//  Encoder (per bit u, delay line r[5:0], r[0]=previous bit)
//   - A=u^r[1]^r[2]^r[4]^r[5]
//   - B=u^r[0]^r[1]^r[2]^r[5]
//   - r<={r[4:0],u}
//   - Scrambler and encoder state advance only on accepted beats or loaded tail words.
// STRUCTURE
//  - Shared package holds: POLY_G0=7'o133, POLY_G1=7'o171, SCR_W=7,
//    and the FSM state encoding (IDLE/DATA/TAIL).
//  - One sub-module, conv_enc_k7: combinational 3-bit-in/6-bit-out step.
//    Inputs: u[2:0], r[5:0]. Outputs: coded[5:0], r_next[5:0]. Instantiated once.
//  - Scrambler step is inline. Top level owns the FSM, the output register and the tail counter.
// TESTING
//  1 SEED=7'h7F, frame of zero payload beats, ACK_I=1
//    -> word0=6'h00, word1=6'h1C (scrambler sequence 0000111...).
//  2 CYC_I pulse with no STB_I
//    -> exactly 2 tail words 6'h00; CYC_O high from the cycle after IDLE until the 2nd tail ACK, then 0.
//  3 ACK_I low for 5 cycles mid-frame
//    -> DAT_O/STB_O held; ACK_O=0 throughout; no beat lost or duplicated vs. golden model.
//  4 RST_I asserted mid-DATA, asynchronously
//    -> outputs 0 immediately. The next frame reproduces test 1 bit-exactly.
//  5 Back-to-back frames, CYC_I re-raised during TAIL
//    -> no ACK_O until tail completes. 2nd frame restarts from SEED.
//  6 Random 200-beat payload, random ACK_I stalls
//    -> output stream matches a bit-serial reference scrambler+encoder including the tail.

Source files
------------

// File: rtl/scramble_conv_enc_pkg.sv
// Shared constants and types for the 802.11 scrambler + K=7 convolutional encoder front end.
package scramble_conv_enc_pkg;
  localparam int SCR_W = 7;
  localparam logic [6:0] POLY_G0 = 7'o133;
  localparam logic [6:0] POLY_G1 = 7'o171;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2
  } state_t;

  // Tap window aligned to the generator polynomials: bit 6 is the current bit, bit 0 the oldest.
  function automatic logic [6:0] tap_window(input logic u, input logic [5:0] r);
    return {u, r[0], r[1], r[2], r[3], r[4], r[5]};
  endfunction
endpackage

// File: rtl/scramble_conv_enc_k7.sv
// Combinational rate-1/2 K=7 encoder step: 3 input bits in, 6 coded bits out.
module conv_enc_k7
  import scramble_conv_enc_pkg::*;
(
  input  logic [2:0] u,
  input  logic [5:0] r,
  output logic [5:0] coded,
  output logic [5:0] r_next
);
  logic [5:0] sr;
  logic [6:0] win;

  always_comb begin
    sr    = r;
    win   = '0;
    coded = '0;
    for (int k = 0; k < 3; k++) begin
      win          = tap_window(u[k], sr);
      coded[2*k]   = ^(win & POLY_G0);
      coded[2*k+1] = ^(win & POLY_G1);
      sr           = {sr[4:0], u[k]};
    end
    r_next = sr;
  end
endmodule

// File: rtl/scramble_conv_enc.sv
// Scrambles 3 payload bits per beat, convolutionally encodes them to 6 bits and appends a zero tail.
module scramble_conv_enc
  import scramble_conv_enc_pkg::*;
#(
  parameter logic [SCR_W-1:0] SEED       = 7'h7F,
  parameter int               TAIL_BEATS = 2
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic [2:0] DAT_I,
  input  logic       CYC_I,
  input  logic       STB_I,
  input  logic       WE_I,
  output logic       ACK_O,
  output logic [5:0] DAT_O,
  output logic       CYC_O,
  output logic       STB_O,
  output logic       WE_O,
  input  logic       ACK_I
);
  localparam int CNT_W = $clog2(TAIL_BEATS + 1);
  localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(TAIL_BEATS);

  state_t           state, state_nxt;
  logic [SCR_W-1:0] scr, scr_nxt, s;
  logic [5:0]       enc, enc_nxt, coded;
  logic [2:0]       scr_bits, enc_u;
  logic [CNT_W-1:0] tail_cnt;
  logic             out_free, beat_acc, tail_load, tail_done, frame_start, x;

  assign out_free = ~STB_O | ACK_I;
  assign ACK_O    = beat_acc;
  assign WE_O     = STB_O;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (CYC_I) state_nxt = DATA;
      DATA:    if (!CYC_I) state_nxt = TAIL;
      TAIL:    if (tail_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A word still waiting for ACK_I blocks both payload acceptance and tail loading.
  always_comb begin
    frame_start = 1'b0;
    beat_acc    = 1'b0;
    tail_load   = 1'b0;
    tail_done   = 1'b0;
    case (state)
      IDLE: frame_start = CYC_I;
      DATA: beat_acc = CYC_I & STB_I & WE_I & out_free;
      TAIL: begin
        tail_load = out_free & (tail_cnt != TAIL_LAST);
        tail_done = out_free & (tail_cnt == TAIL_LAST);
      end
      default: ;
    endcase
  end

  always_comb begin
    s        = scr;
    x        = 1'b0;
    scr_bits = '0;
    for (int k = 0; k < 3; k++) begin
      x           = s[6] ^ s[3];
      scr_bits[k] = DAT_I[k] ^ x;
      s           = {s[5:0], x};
    end
    scr_nxt = s;
  end

  // Tail bits bypass the scrambler so the trellis is flushed to the all-zero state.
  assign enc_u = (state == TAIL) ? 3'b000 : scr_bits;

  conv_enc_k7 u_enc (
    .u      (enc_u),
    .r      (enc),
    .coded  (coded),
    .r_next (enc_nxt)
  );

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      scr      <= '0;
      enc      <= '0;
      DAT_O    <= '0;
      STB_O    <= 1'b0;
      CYC_O    <= 1'b0;
      tail_cnt <= '0;
    end else begin
      if (frame_start) begin
        scr      <= SEED;
        enc      <= '0;
        CYC_O    <= 1'b1;
        tail_cnt <= '0;
      end
      if (beat_acc) begin
        scr   <= scr_nxt;
        enc   <= enc_nxt;
        DAT_O <= coded;
        STB_O <= 1'b1;
      end else if (tail_load) begin
        enc      <= enc_nxt;
        DAT_O    <= coded;
        STB_O    <= 1'b1;
        tail_cnt <= tail_cnt + 1'b1;
      end else if (STB_O & ACK_I) begin
        STB_O <= 1'b0;
      end
      if (tail_done) CYC_O <= 1'b0;
    end
  end
endmodule
